// File: rtl/histeq_pkg.sv
// Shared definitions for the histogram-equalisation pipeline: FSM state
// encoding and the default data-path widths used by every stage.
package histeq_pkg;

    localparam int PIXEL_W    = 8;
    localparam int COUNT_W    = 20;
    localparam int NUM_BINS   = 2 ** PIXEL_W;
    localparam int NUM_PIXELS = 65536;
    localparam int M1_ADDR_W  = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ACCUM = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/histogram_input_if.sv
// Control handshake plus M1 image-memory and M2 scratchpad buses of the
// histogram input stage. The stage itself uses the master view; the
// controller and memories use the slave view.
interface histogram_input_if #(
    parameter int PIXEL_W   = histeq_pkg::PIXEL_W,
    parameter int COUNT_W   = histeq_pkg::COUNT_W,
    parameter int M1_ADDR_W = histeq_pkg::M1_ADDR_W
);

    logic                 input_start;
    logic                 input_base_offset;
    logic [PIXEL_W-1:0]   M1_ReadBus;
    logic [M1_ADDR_W-1:0] M1_ReadAddress;
    logic [COUNT_W-1:0]   SP_ReadBus;
    logic [PIXEL_W:0]     SP_ReadAddress;
    logic [COUNT_W-1:0]   SP_WriteBus;
    logic [PIXEL_W:0]     SP_WriteAddress;
    logic                 SP_WriteEnable;
    logic                 input_done;
    logic                 busy;

    modport master (
        input  input_start,
        input  input_base_offset,
        input  M1_ReadBus,
        input  SP_ReadBus,
        output M1_ReadAddress,
        output SP_ReadAddress,
        output SP_WriteBus,
        output SP_WriteAddress,
        output SP_WriteEnable,
        output input_done,
        output busy
    );

    modport slave (
        output input_start,
        output input_base_offset,
        output M1_ReadBus,
        output SP_ReadBus,
        input  M1_ReadAddress,
        input  SP_ReadAddress,
        input  SP_WriteBus,
        input  SP_WriteAddress,
        input  SP_WriteEnable,
        input  input_done,
        input  busy
    );

endinterface

// File: rtl/hist_rmw_pipe.sv
// Read-modify-write pipeline for histogram bins. S1 issues the scratchpad
// read for the incoming pixel and captures its bin; S2 writes back the
// saturating increment. Because a read issued in the same cycle as a write
// to the same bin returns stale data, the previous S2 result is forwarded
// when two consecutive pixels hit the same bin.
module hist_rmw_pipe #(
    parameter int PIXEL_W = histeq_pkg::PIXEL_W,
    parameter int COUNT_W = histeq_pkg::COUNT_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               issue_i,
    input  logic               bank_i,
    input  logic [PIXEL_W-1:0] pix_i,
    input  logic [COUNT_W-1:0] rd_data_i,
    output logic [PIXEL_W:0]   rd_addr_o,
    output logic               wr_en_o,
    output logic [PIXEL_W:0]   wr_addr_o,
    output logic [COUNT_W-1:0] wr_data_o
);

    localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

    // Counter increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return CNT_MAX;
        end else begin
            return v + COUNT_W'(1);
        end
    endfunction

    logic               s1_valid_q;
    logic               s2_valid_q;
    logic [PIXEL_W-1:0] s2_bin_q;
    logic               fwd_valid_q;
    logic [PIXEL_W-1:0] fwd_bin_q;
    logic [COUNT_W-1:0] fwd_data_q;
    logic [COUNT_W-1:0] cnt_s;

    // Stage valids, bin capture and the one-deep history of the last write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_bin_q    <= {PIXEL_W{1'b0}};
            fwd_valid_q <= 1'b0;
            fwd_bin_q   <= {PIXEL_W{1'b0}};
            fwd_data_q  <= {COUNT_W{1'b0}};
        end else begin
            s1_valid_q  <= issue_i;
            s2_valid_q  <= s1_valid_q;
            s2_bin_q    <= pix_i;
            fwd_valid_q <= s2_valid_q;
            fwd_bin_q   <= s2_bin_q;
            fwd_data_q  <= wr_data_o;
        end
    end

    // Read address, forwarding select and write-back of the incremented bin.
    always_comb begin
        rd_addr_o = {(PIXEL_W + 1){1'b0}};
        wr_en_o   = 1'b0;
        wr_addr_o = {(PIXEL_W + 1){1'b0}};
        wr_data_o = {COUNT_W{1'b0}};
        cnt_s     = rd_data_i;

        if (s1_valid_q) begin
            rd_addr_o = {bank_i, pix_i};
        end else begin
            rd_addr_o = {(PIXEL_W + 1){1'b0}};
        end

        // Back-to-back hit on the same bin: the memory still holds the old count.
        if (fwd_valid_q && (fwd_bin_q == s2_bin_q)) begin
            cnt_s = fwd_data_q;
        end else begin
            cnt_s = rd_data_i;
        end

        if (s2_valid_q) begin
            wr_en_o   = 1'b1;
            wr_addr_o = {bank_i, s2_bin_q};
            wr_data_o = sat_inc(cnt_s);
        end else begin
            wr_en_o   = 1'b0;
            wr_addr_o = {(PIXEL_W + 1){1'b0}};
            wr_data_o = {COUNT_W{1'b0}};
        end
    end

endmodule

// File: rtl/histogram_input.sv
// Histogram input stage: on start, zero one scratchpad bank, then stream a
// full frame from M1 and count each pixel value into that bank. The bank
// select lets the next frame be binned while the CDF stage drains the other.
module histogram_input #(
    parameter int PIXEL_W    = histeq_pkg::PIXEL_W,
    parameter int COUNT_W    = histeq_pkg::COUNT_W,
    parameter int NUM_PIXELS = histeq_pkg::NUM_PIXELS,
    parameter int M1_ADDR_W  = histeq_pkg::M1_ADDR_W
) (
    input  logic              clock,
    input  logic              reset_n,   // active-high synchronous reset
    histogram_input_if.master bus
);

    import histeq_pkg::*;

    localparam logic [PIXEL_W-1:0]   LAST_BIN = {PIXEL_W{1'b1}};
    localparam logic [M1_ADDR_W-1:0] LAST_PIX = M1_ADDR_W'(NUM_PIXELS - 1);

    state_e               state_q;
    state_e               state_d;
    logic [PIXEL_W-1:0]   clr_cnt_q;
    logic [PIXEL_W-1:0]   clr_cnt_d;
    logic [M1_ADDR_W-1:0] pix_cnt_q;
    logic [M1_ADDR_W-1:0] pix_cnt_d;
    logic                 bank_q;
    logic                 bank_d;
    logic                 drain_q;
    logic                 drain_d;
    logic                 issue_s;

    logic [PIXEL_W:0]     pipe_rd_addr_s;
    logic                 pipe_wr_en_s;
    logic [PIXEL_W:0]     pipe_wr_addr_s;
    logic [COUNT_W-1:0]   pipe_wr_data_s;

    hist_rmw_pipe #(
        .PIXEL_W (PIXEL_W),
        .COUNT_W (COUNT_W)
    ) u_rmw_pipe (
        .clk_i     (clock),
        .rst_i     (reset_n),
        .issue_i   (issue_s),
        .bank_i    (bank_q),
        .pix_i     (bus.M1_ReadBus),
        .rd_data_i (bus.SP_ReadBus),
        .rd_addr_o (pipe_rd_addr_s),
        .wr_en_o   (pipe_wr_en_s),
        .wr_addr_o (pipe_wr_addr_s),
        .wr_data_o (pipe_wr_data_s)
    );

    // FSM state, latched bank and the clear/pixel/drain counters.
    always_ff @(posedge clock) begin
        if (reset_n) begin
            state_q   <= IDLE;
            clr_cnt_q <= {PIXEL_W{1'b0}};
            pix_cnt_q <= {M1_ADDR_W{1'b0}};
            bank_q    <= 1'b0;
            drain_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            pix_cnt_q <= pix_cnt_d;
            bank_q    <= bank_d;
            drain_q   <= drain_d;
        end
    end

    // Next-state logic; start is only honoured while idle.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        pix_cnt_d = pix_cnt_q;
        bank_d    = bank_q;
        drain_d   = drain_q;
        issue_s   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.input_start) begin
                    bank_d    = bus.input_base_offset;
                    clr_cnt_d = {PIXEL_W{1'b0}};
                    pix_cnt_d = {M1_ADDR_W{1'b0}};
                    drain_d   = 1'b0;
                    state_d   = CLEAR;
                end else begin
                    state_d   = IDLE;
                end
            end
            CLEAR: begin
                // Counter wraps back to zero on the last bin.
                clr_cnt_d = clr_cnt_q + PIXEL_W'(1);
                if (clr_cnt_q == LAST_BIN) begin
                    state_d = ACCUM;
                end else begin
                    state_d = CLEAR;
                end
            end
            ACCUM: begin
                issue_s = 1'b1;
                if (pix_cnt_q == LAST_PIX) begin
                    pix_cnt_d = {M1_ADDR_W{1'b0}};
                    state_d   = DRAIN;
                end else begin
                    pix_cnt_d = pix_cnt_q + M1_ADDR_W'(1);
                    state_d   = ACCUM;
                end
            end
            DRAIN: begin
                // Two cycles let the last pixel pass S1 and S2.
                drain_d = ~drain_q;
                if (drain_q) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode: clear writes and pipeline writes never overlap in time.
    always_comb begin
        bus.M1_ReadAddress  = {M1_ADDR_W{1'b0}};
        bus.SP_ReadAddress  = pipe_rd_addr_s;
        bus.SP_WriteEnable  = 1'b0;
        bus.SP_WriteAddress = {(PIXEL_W + 1){1'b0}};
        bus.SP_WriteBus     = {COUNT_W{1'b0}};
        bus.input_done      = (state_q == DONE);
        bus.busy            = (state_q != IDLE);

        if (state_q == ACCUM) begin
            bus.M1_ReadAddress = pix_cnt_q;
        end else begin
            bus.M1_ReadAddress = {M1_ADDR_W{1'b0}};
        end

        if (state_q == CLEAR) begin
            bus.SP_WriteEnable  = 1'b1;
            bus.SP_WriteAddress = {bank_q, clr_cnt_q};
            bus.SP_WriteBus     = {COUNT_W{1'b0}};
        end else begin
            bus.SP_WriteEnable  = pipe_wr_en_s;
            bus.SP_WriteAddress = pipe_wr_addr_s;
            bus.SP_WriteBus     = pipe_wr_data_s;
        end
    end

endmodule

// File: tb/tb_histogram_input.sv
// Bench for histogram_input. Two instances: A with 20-bit counters and a
// 4-pixel frame, B with 3-bit counters and a 10-pixel frame for saturation.
// Every expected scratchpad write is queued when a frame is launched and
// popped as the DUT writes.
module tb_histogram_input;

    localparam int PW   = 8;
    localparam int AW   = 16;
    localparam int CW_A = 20;
    localparam int NP_A = 4;
    localparam int CW_B = 3;
    localparam int NP_B = 10;

    typedef struct packed {
        logic [8:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;

    always #5 clock = ~clock;

    histogram_input_if #(.PIXEL_W(PW), .COUNT_W(CW_A), .M1_ADDR_W(AW)) bus_a ();
    histogram_input_if #(.PIXEL_W(PW), .COUNT_W(CW_B), .M1_ADDR_W(AW)) bus_b ();

    histogram_input #(.PIXEL_W(PW), .COUNT_W(CW_A), .NUM_PIXELS(NP_A), .M1_ADDR_W(AW)) dut_a (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    histogram_input #(.PIXEL_W(PW), .COUNT_W(CW_B), .NUM_PIXELS(NP_B), .M1_ADDR_W(AW)) dut_b (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_b)
    );

    logic [PW-1:0]   m1_a [0:15];
    logic [PW-1:0]   m1_b [0:15];
    logic [CW_A-1:0] sp_a [0:511];
    logic [CW_B-1:0] sp_b [0:511];
    logic [PW-1:0]   pix_buf [0:15];

    wr_t exp_a [$];
    wr_t exp_b [$];
    wr_t wa;
    wr_t wb;
    int  extra_a = 0;
    int  extra_b = 0;
    int  n_checks = 0;
    int  n_errors = 0;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Memory models: synchronous read, one-cycle latency, old data on collision.
    always @(posedge clock) begin
        bus_a.M1_ReadBus <= m1_a[bus_a.M1_ReadAddress[3:0]];
        bus_a.SP_ReadBus <= sp_a[bus_a.SP_ReadAddress];
        if (bus_a.SP_WriteEnable) sp_a[bus_a.SP_WriteAddress] <= bus_a.SP_WriteBus;
        bus_b.M1_ReadBus <= m1_b[bus_b.M1_ReadAddress[3:0]];
        bus_b.SP_ReadBus <= sp_b[bus_b.SP_ReadAddress];
        if (bus_b.SP_WriteEnable) sp_b[bus_b.SP_WriteAddress] <= bus_b.SP_WriteBus;
    end

    // Scoreboard for instance A writes.
    always @(negedge clock) begin
        if (bus_a.SP_WriteEnable) begin
            if (exp_a.size() == 0) begin
                extra_a++;
            end else begin
                wa = exp_a.pop_front();
                chk_eq("wr_a_addr", 64'(bus_a.SP_WriteAddress), 64'(wa.addr));
                chk_eq("wr_a_data", 64'(bus_a.SP_WriteBus), 64'(wa.data));
            end
        end
    end

    // Scoreboard for instance B writes.
    always @(negedge clock) begin
        if (bus_b.SP_WriteEnable) begin
            if (exp_b.size() == 0) begin
                extra_b++;
            end else begin
                wb = exp_b.pop_front();
                chk_eq("wr_b_addr", 64'(bus_b.SP_WriteAddress), 64'(wb.addr));
                chk_eq("wr_b_data", 64'(bus_b.SP_WriteBus), 64'(wb.data));
            end
        end
    end

    function automatic logic [63:0] outs(input bit sel_b);
        if (sel_b) begin
            return 64'({bus_b.M1_ReadAddress, bus_b.SP_ReadAddress, bus_b.SP_WriteAddress,
                        bus_b.SP_WriteBus, bus_b.SP_WriteEnable, bus_b.input_done, bus_b.busy});
        end else begin
            return 64'({bus_a.M1_ReadAddress, bus_a.SP_ReadAddress, bus_a.SP_WriteAddress,
                        bus_a.SP_WriteBus, bus_a.SP_WriteEnable, bus_a.input_done, bus_a.busy});
        end
    endfunction

    function automatic bit get_done(input bit sel_b);
        return sel_b ? bus_b.input_done : bus_a.input_done;
    endfunction

    function automatic bit get_busy(input bit sel_b);
        return sel_b ? bus_b.busy : bus_a.busy;
    endfunction

    task automatic set_start(input bit sel_b, input bit s, input bit bank);
        if (sel_b) begin
            bus_b.input_start       = s;
            bus_b.input_base_offset = bank;
        end else begin
            bus_a.input_start       = s;
            bus_a.input_base_offset = bank;
        end
    endtask

    // Launch one frame of n pixels from pix_buf; optionally pulse a second
    // start mid-frame, or abort with reset at cycle abort_at (0 = no abort).
    // Cycle numbering counts the cycle in which start is high as cycle 1.
    task automatic run_frame(input bit sel_b, input bit bank, input int n,
                             input bit mid_start, input int abort_at);
        int  hist [256];
        int  maxv, lat, cyc, busy_drops, dones, b;
        bit  got;
        wr_t w;
        maxv = sel_b ? (2 ** CW_B) - 1 : (2 ** CW_A) - 1;
        for (int i = 0; i < 256; i++) hist[i] = 0;
        for (int i = 0; i < 256; i++) begin
            w.addr = {bank, 8'(i)};
            w.data = 32'd0;
            if (sel_b) exp_b.push_back(w); else exp_a.push_back(w);
        end
        for (int i = 0; i < n; i++) begin
            b = int'(pix_buf[i]);
            if (hist[b] < maxv) hist[b]++;
            w.addr = {bank, pix_buf[i]};
            w.data = 32'(hist[b]);
            if (sel_b) begin
                exp_b.push_back(w);
                m1_b[i] = pix_buf[i];
            end else begin
                exp_a.push_back(w);
                m1_a[i] = pix_buf[i];
            end
        end

        lat = 1 + 256 + n + 3;
        @(negedge clock);
        set_start(sel_b, 1'b1, bank);
        cyc = 1;
        @(negedge clock);
        set_start(sel_b, 1'b0, 1'b0);
        cyc = 2;
        chk_eq("busy_after_start", 64'(get_busy(sel_b)), 64'd1);
        got = 1'b0;
        busy_drops = 0;
        while (!got && cyc <= lat + 8) begin
            if (abort_at != 0 && cyc == abort_at) begin
                reset_n = 1'b1;
                @(negedge clock);
                chk_eq("abort_outs_zero", outs(sel_b), 64'd0);
                reset_n = 1'b0;
                dones = 0;
                repeat (lat) begin
                    @(negedge clock);
                    if (get_done(sel_b)) dones++;
                end
                chk_eq("abort_no_done", 64'(dones), 64'd0);
                chk_eq("abort_idle", 64'(get_busy(sel_b)), 64'd0);
                if (sel_b) exp_b.delete(); else exp_a.delete();
                return;
            end
            if (mid_start && cyc == 100) set_start(sel_b, 1'b1, ~bank);
            if (mid_start && cyc == 101) set_start(sel_b, 1'b0, 1'b0);
            if (get_done(sel_b)) begin
                got = 1'b1;
            end else begin
                if (!get_busy(sel_b)) busy_drops++;
                @(negedge clock);
                cyc++;
            end
        end
        chk_eq("done_cycle", got ? 64'(cyc) : 64'd0, 64'(lat));
        chk_eq("busy_held", 64'(busy_drops), 64'd0);
        @(negedge clock);
        chk_eq("done_one_cycle", 64'(get_done(sel_b)), 64'd0);
        chk_eq("busy_idle", 64'(get_busy(sel_b)), 64'd0);
        chk_eq("sb_drained", sel_b ? 64'(exp_b.size()) : 64'(exp_a.size()), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        set_start(1'b0, 1'b0, 1'b0);
        set_start(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            m1_a[i] = 8'd0;
            m1_b[i] = 8'd0;
        end

        // Reset held for three cycles, then released.
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        chk_eq("reset_outs_a", outs(1'b0), 64'd0);
        chk_eq("reset_outs_b", outs(1'b1), 64'd0);
        reset_n = 1'b0;
        @(negedge clock);
        chk_eq("idle_outs_a", outs(1'b0), 64'd0);

        // Distinct pixels into bank 1, with a stray start during CLEAR.
        pix_buf[0] = 8'd3; pix_buf[1] = 8'd7; pix_buf[2] = 8'd9; pix_buf[3] = 8'd200;
        run_frame(1'b0, 1'b1, NP_A, 1'b1, 0);
        chk_eq("distinct_bin3", 64'(sp_a[256 + 3]), 64'd1);
        chk_eq("distinct_bin7", 64'(sp_a[256 + 7]), 64'd1);
        chk_eq("distinct_bin9", 64'(sp_a[256 + 9]), 64'd1);
        chk_eq("distinct_bin200", 64'(sp_a[256 + 200]), 64'd1);
        chk_eq("distinct_bin4", 64'(sp_a[256 + 4]), 64'd0);

        // Back-to-back repeats exercise forwarding.
        pix_buf[0] = 8'd5; pix_buf[1] = 8'd5; pix_buf[2] = 8'd5; pix_buf[3] = 8'd5;
        run_frame(1'b0, 1'b0, NP_A, 1'b0, 0);
        chk_eq("repeat_bin5", 64'(sp_a[5]), 64'd4);

        pix_buf[0] = 8'd5; pix_buf[1] = 8'd6; pix_buf[2] = 8'd5; pix_buf[3] = 8'd6;
        run_frame(1'b0, 1'b0, NP_A, 1'b0, 0);
        chk_eq("alt_bin5", 64'(sp_a[5]), 64'd2);
        chk_eq("alt_bin6", 64'(sp_a[6]), 64'd2);
        chk_eq("other_bank_kept", 64'(sp_a[256 + 200]), 64'd1);

        // Saturation with 3-bit counters: ten zeros stop at 7.
        for (int i = 0; i < NP_B; i++) pix_buf[i] = 8'd0;
        run_frame(1'b1, 1'b0, NP_B, 1'b0, 0);
        chk_eq("sat_bin0", 64'(sp_b[0]), 64'd7);

        // Abort mid-ACCUM, then a clean frame.
        pix_buf[0] = 8'd1; pix_buf[1] = 8'd2; pix_buf[2] = 8'd3; pix_buf[3] = 8'd4;
        run_frame(1'b0, 1'b1, NP_A, 1'b0, 259);
        pix_buf[0] = 8'd8; pix_buf[1] = 8'd8; pix_buf[2] = 8'd9; pix_buf[3] = 8'd8;
        run_frame(1'b0, 1'b1, NP_A, 1'b0, 0);
        chk_eq("post_abort_bin8", 64'(sp_a[256 + 8]), 64'd3);
        chk_eq("post_abort_bin9", 64'(sp_a[256 + 9]), 64'd1);
        chk_eq("post_abort_bin3", 64'(sp_a[256 + 3]), 64'd0);

        repeat (3) @(negedge clock);
        chk_eq("extra_writes_a", 64'(extra_a), 64'd0);
        chk_eq("extra_writes_b", 64'(extra_b), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
